// File: rtl/lfsr_stim_bank.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_stim_bank
//  Purpose  : Multi-channel pseudo-random stimulus source. NUM_CH channels of
//             WIDTH bits, each built from 32-bit Galois LFSR slices, with an
//             IDLE/RUN/RESEED controller, per-channel valid/ready, free-run
//             stepping and a saturating RUN-cycle counter.
//  Options  : define LFSR_STIM_SIGNATURE_EN to build the 32-bit MISR that
//             compresses every stepped channel value into 'signature'.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_stim_bank #(
   parameter int          NUM_CH = 4,
   parameter int          WIDTH  = 128,
   parameter logic [31:0] SEED   = 32'h00000001,
   parameter int          CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     free_run,
   input  logic                     reseed_req,
   input  logic [31:0]              reseed_val,
   output logic                     reseed_done,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH-1:0]        out_valid,
   output logic [NUM_CH*WIDTH-1:0]  data_out,
   output logic                     busy,
   output logic [CNT_W-1:0]         cycle_count,
   output logic [31:0]              signature
);

   localparam int          SLICES   = (WIDTH + 31) / 32;
   localparam int          TOTAL    = NUM_CH * SLICES;
   localparam logic [31:0] C_GOLDEN = 32'h9E3779B9;
   localparam logic [31:0] C_TAPS   = 32'h80200003;

   // Seed of slice k: spread the base seed by the golden-ratio increment.
   // An all-zero LFSR would lock up, so zero is replaced by one.
   function automatic logic [31:0] seedFor(input logic [31:0] base, input int k);
      logic [31:0] v;
      v = base + (32'(k) * C_GOLDEN);
      return (v == 32'h0) ? 32'h00000001 : v;
   endfunction

   // One step of the 32-bit right-shifting Galois LFSR.
   function automatic logic [31:0] lfsrStep(input logic [31:0] cur);
      return (cur >> 1) ^ (cur[0] ? C_TAPS : 32'h0);
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_RESEED = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic              w_reseedAccept;
   logic [NUM_CH-1:0] w_stepEn;
   logic              r_reseedDone;
   logic [CNT_W-1:0]  r_cycleCount;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state, handshake outputs and per-channel step enables.
   // A reseed request outranks enable and suppresses any step in the same
   // cycle, so the reload always wins over a concurrent step.
   always_comb begin
      w_nextState    = r_state;
      out_valid      = '0;
      busy           = 1'b0;
      w_reseedAccept = 1'b0;
      w_stepEn       = '0;
      case (r_state)
         ST_IDLE: begin
            if (reseed_req) begin
               w_reseedAccept = 1'b1;
               w_nextState    = ST_RESEED;
            end else if (enable) begin
               w_nextState = ST_RUN;
            end
         end
         ST_RUN: begin
            out_valid = '1;
            busy      = 1'b1;
            if (reseed_req) begin
               w_reseedAccept = 1'b1;
               w_nextState    = ST_RESEED;
            end else begin
               w_stepEn = out_ready | {NUM_CH{free_run}};
               if (!enable) begin
                  w_nextState = ST_IDLE;
               end
            end
         end
         ST_RESEED: begin
            busy        = 1'b1;
            w_nextState = enable ? ST_RUN : ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Completion pulse in the cycle that follows the single RESEED cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_reseedDone <= 1'b0;
      end else begin
         r_reseedDone <= (r_state == ST_RESEED);
      end
   end

   // RUN-cycle counter, sticks at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cycleCount <= '0;
      end else if ((r_state == ST_RUN) && (r_cycleCount != '1)) begin
         r_cycleCount <= r_cycleCount + CNT_W'(1);
      end
   end

   assign reseed_done = r_reseedDone;
   assign cycle_count = r_cycleCount;

`ifdef LFSR_STIM_SIGNATURE_EN
   // Running XOR of the pre-step words of every stepping channel.
   logic [TOTAL:0][31:0] w_foldChain;
   assign w_foldChain[0] = 32'h0;
`endif

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         for (genvar s = 0; s < SLICES; s++) begin : g_sl
            localparam int          K        = c * SLICES + s;
            localparam int          SW       = ((WIDTH - s * 32) >= 32) ? 32 : (WIDTH - s * 32);
            localparam logic [31:0] C_MASK   = (SW == 32) ? 32'hFFFFFFFF : ((32'h1 << SW) - 32'h1);
            localparam logic [31:0] C_RSTVAL = seedFor(SEED, K);

            logic [31:0] r_slice;

            // Slice state: reload on reseed acceptance, otherwise step when
            // its channel is enabled; holds in every other case.
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  r_slice <= C_RSTVAL;
               end else if (w_reseedAccept) begin
                  r_slice <= seedFor(reseed_val, K);
               end else if (w_stepEn[c]) begin
                  r_slice <= lfsrStep(r_slice);
               end
            end

            // Slice 0 fills the channel LSBs; the top slice is truncated.
            assign data_out[c * WIDTH + s * 32 +: SW] = r_slice[SW-1:0];

`ifdef LFSR_STIM_SIGNATURE_EN
            assign w_foldChain[K+1] = w_foldChain[K] ^
                                      (w_stepEn[c] ? (r_slice & C_MASK) : 32'h0);
`endif
         end
      end
   endgenerate

`ifdef LFSR_STIM_SIGNATURE_EN
   logic [31:0] r_signature;

   // MISR update on any cycle in which at least one channel steps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_signature <= 32'h0;
      end else if (|w_stepEn) begin
         r_signature <= lfsrStep(r_signature) ^ w_foldChain[TOTAL];
      end
   end

   assign signature = r_signature;
`else
   assign signature = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stim_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_stim_bank
//  Purpose  : Directed self-checking bench for lfsr_stim_bank with two 32-bit
//             channels, base seed 1 and a 4-bit cycle counter. Optional
//             signature checks follow LFSR_STIM_SIGNATURE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_stim_bank;

   localparam int NUM_CH = 2;
   localparam int WIDTH  = 32;
   localparam int CNT_W  = 4;

   logic                    clk;
   logic                    reset_n;
   logic                    enable;
   logic                    free_run;
   logic                    reseed_req;
   logic [31:0]             reseed_val;
   logic                    reseed_done;
   logic [NUM_CH-1:0]       out_ready;
   logic [NUM_CH-1:0]       out_valid;
   logic [NUM_CH*WIDTH-1:0] data_out;
   logic                    busy;
   logic [CNT_W-1:0]        cycle_count;
   logic [31:0]             signature;

   int nCmp  = 0;
   int nFail = 0;

   lfsr_stim_bank #(
      .NUM_CH (NUM_CH),
      .WIDTH  (WIDTH),
      .SEED   (32'h00000001),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .free_run    (free_run),
      .reseed_req  (reseed_req),
      .reseed_val  (reseed_val),
      .reseed_done (reseed_done),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .data_out    (data_out),
      .busy        (busy),
      .cycle_count (cycle_count),
      .signature   (signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand-derived LFSR sequences.
   // ch0 from 1: s0..s7 ; ch1 from 9E3779BA: t0..t5
   localparam logic [31:0] S0 = 32'h00000001;
   localparam logic [31:0] S1 = 32'h80200003;
   localparam logic [31:0] S2 = 32'hC0300002;
   localparam logic [31:0] S5 = 32'hD8360002;
   localparam logic [31:0] S7 = 32'hB62D8003;
   localparam logic [31:0] T0 = 32'h9E3779BA;
   localparam logic [31:0] T5 = 32'hF4CDBBCF;

   initial begin
      reset_n    = 1'b1;
      enable     = 1'b0;
      free_run   = 1'b0;
      reseed_req = 1'b0;
      reseed_val = 32'h0;
      out_ready  = '0;
      #2 reset_n = 1'b0;
      #1;
      // Reset state
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_count", 64'(cycle_count), 64'h0);
      chk("rst_ch0", 64'(data_out[31:0]), 64'(S0));
      chk("rst_ch1", 64'(data_out[63:32]), 64'(T0));
      chk("rst_done", 64'(reseed_done), 64'h0);
      chk("rst_sig", 64'(signature), 64'h0);

      tick();
      tick();
      reset_n   = 1'b1;
      enable    = 1'b1;
      out_ready = 2'b01;

      // IDLE -> RUN, first value presented
      tick();
      chk("run_valid", 64'(out_valid), 64'h3);
      chk("run_busy", 64'(busy), 64'h1);
      chk("run_ch0_s0", 64'(data_out[31:0]), 64'(S0));
      chk("run_count0", 64'(cycle_count), 64'h0);

      tick();
      chk("ch0_s1", 64'(data_out[31:0]), 64'(S1));
      chk("ch1_hold1", 64'(data_out[63:32]), 64'(T0));
      chk("count1", 64'(cycle_count), 64'h1);
`ifdef LFSR_STIM_SIGNATURE_EN
      chk("sig_one_step", 64'(signature), 64'h1);
`else
      chk("sig_tied0", 64'(signature), 64'h0);
`endif

      tick();
      chk("ch0_s2", 64'(data_out[31:0]), 64'(S2));
      chk("ch1_hold2", 64'(data_out[63:32]), 64'(T0));

      // Dropped ready: no step
      out_ready = 2'b00;
      tick();
      chk("stall_ch0", 64'(data_out[31:0]), 64'(S2));
      chk("stall_count", 64'(cycle_count), 64'h3);

      // Free run, ready low, 5 cycles
      free_run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("fr_valid", 64'(out_valid), 64'h3);
      end
      chk("fr_ch0", 64'(data_out[31:0]), 64'(S7));
      chk("fr_ch1", 64'(data_out[63:32]), 64'(T5));
      chk("fr_count", 64'(cycle_count), 64'h8);

      // Reseed from base 0 in RUN, concurrent free-run step discarded
      reseed_val = 32'h0;
      reseed_req = 1'b1;
      tick();
      reseed_req = 1'b0;
      free_run   = 1'b0;
      chk("rs_ch0", 64'(data_out[31:0]), 64'h1);
      chk("rs_ch1", 64'(data_out[63:32]), 64'h9E3779B9);
      chk("rs_valid", 64'(out_valid), 64'h0);
      chk("rs_busy", 64'(busy), 64'h1);
      chk("rs_done_early", 64'(reseed_done), 64'h0);
      chk("rs_count", 64'(cycle_count), 64'h9);

      tick();
      chk("rs_done", 64'(reseed_done), 64'h1);
      chk("rs_resume_valid", 64'(out_valid), 64'h3);
      chk("rs_count_hold", 64'(cycle_count), 64'h9);

      tick();
      chk("rs_done_pulse", 64'(reseed_done), 64'h0);
      chk("rs_ch0_hold", 64'(data_out[31:0]), 64'h1);

      // enable=0 mid-stream: last RUN cycle still steps, then frozen
      out_ready = 2'b01;
      enable    = 1'b0;
      tick();
      chk("idle_valid", 64'(out_valid), 64'h0);
      chk("idle_busy", 64'(busy), 64'h0);
      chk("idle_ch0", 64'(data_out[31:0]), 64'(S1));
      tick();
      chk("idle_frozen", 64'(data_out[31:0]), 64'(S1));
      chk("idle_count", 64'(cycle_count), 64'hB);

      enable = 1'b1;
      tick();
      chk("resume_valid", 64'(out_valid), 64'h3);
      chk("resume_ch0", 64'(data_out[31:0]), 64'(S1));
      tick();
      chk("resume_step", 64'(data_out[31:0]), 64'(S2));
      chk("resume_count", 64'(cycle_count), 64'hC);

      // Saturation of the 4-bit counter
      free_run = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("sat_reach", 64'(cycle_count), 64'hF);
      chk("sat_ch0", 64'(data_out[31:0]), 64'(S5));
      for (int i = 0; i < 5; i++) tick();
      chk("sat_hold", 64'(cycle_count), 64'hF);

      // Reset asserted during RESEED
      reseed_val = 32'h12345678;
      reseed_req = 1'b1;
      tick();
      reseed_req = 1'b0;
      chk("pre_rst_busy", 64'(busy), 64'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'h0);
      chk("arst_busy", 64'(busy), 64'h0);
      chk("arst_count", 64'(cycle_count), 64'h0);
      chk("arst_ch0", 64'(data_out[31:0]), 64'(S0));
      chk("arst_ch1", 64'(data_out[63:32]), 64'(T0));
      chk("arst_done", 64'(reseed_done), 64'h0);
      chk("arst_sig", 64'(signature), 64'h0);

      tick();
      reset_n = 1'b1;
      enable  = 1'b0;
      tick();
      chk("post_rst_idle", 64'(out_valid), 64'h0);
      chk("post_rst_done", 64'(reseed_done), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
`default_nettype wire
